// File: rtl/cc_ben_unit.sv
// Condition-code and branch-enable unit: NZP flag decode, NZP register, BEN
// evaluation against the IR mask, and a small LIFO of saved NZP values.
module cc_ben_unit #(
  parameter int         WIDTH       = 16,
  parameter int         STACK_DEPTH = 4,
  parameter bit         BEN_FWD     = 1'b0,
  parameter logic [2:0] RESET_NZP   = 3'b000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [WIDTH-1:0]                   bus,
  input  logic                               ld_cc,
  input  logic                               ld_ben,
  input  logic [2:0]                         ir_nzp,
  input  logic                               cc_wr,
  input  logic [2:0]                         cc_wr_val,
  input  logic                               cc_push,
  input  logic                               cc_pop,
  input  logic                               err_clr,
  output logic [2:0]                         nzp,
  output logic                               ben,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]    nzp_q;
  logic [2:0]    nzp_nxt;
  logic          ben_q;
  logic          err_q;
  logic [DW-1:0] cnt_q;
  logic [2:0]    stk [STACK_DEPTH];

  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          cnt_inc;
  logic          cnt_dec;
  logic          wr_en;
  logic          err_set;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic [2:0]    flags;
  logic [2:0]    ben_src;

  // Bus value is treated as two's complement: negative, zero or positive.
  function automatic logic [2:0] decode_flags(input logic signed [WIDTH-1:0] v);
    if (v == '0)
      return 3'b010;
    else if (v < 0)
      return 3'b100;
    else
      return 3'b001;
  endfunction

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == DW'(STACK_DEPTH));
    top_idx = AW'(cnt_q - DW'(1));
    flags   = decode_flags(bus);

    // A pop on an empty stack is simply ignored; push+pop on a non-empty
    // stack is a swap of the top entry with the current NZP.
    pop_ok  = cc_pop & ~empty;
    cnt_inc = cc_push & ~full & (~cc_pop | empty);
    cnt_dec = cc_pop & ~cc_push & ~empty;
    wr_en   = cc_push & (cc_pop | ~full);
    wr_idx  = pop_ok ? top_idx : AW'(cnt_q);
    err_set = (cc_push & ~cc_pop & full) | (cc_pop & empty);

    if (pop_ok)
      nzp_nxt = stk[top_idx];
    else if (cc_wr)
      nzp_nxt = cc_wr_val;
    else if (ld_cc)
      nzp_nxt = flags;
    else
      nzp_nxt = nzp_q;

    ben_src = BEN_FWD ? nzp_nxt : nzp_q;
  end

  // Control state: NZP, BEN, entry count and the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzp_q <= RESET_NZP;
      ben_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      nzp_q <= nzp_nxt;
      if (ld_ben)
        ben_q <= |(ir_nzp & ben_src);
      if (err_set)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
      if (cnt_inc)
        cnt_q <= cnt_q + DW'(1);
      else if (cnt_dec)
        cnt_q <= cnt_q - DW'(1);
    end
  end

  // Saved-NZP storage carries no reset; only the count defines valid entries.
  always_ff @(posedge clk) begin
    if (reset && wr_en)
      stk[wr_idx] <= nzp_q;
  end

  assign nzp         = nzp_q;
  assign ben         = ben_q;
  assign stack_err   = err_q;
  assign stack_depth = cnt_q;
  assign stack_empty = empty;
  assign stack_full  = full;

endmodule

// File: doc/cc_ben_unit.md
# cc_ben_unit

Parametrised condition-code and branch-enable unit for the SLC-3 datapath: derives N/Z/P from a WIDTH-bit bus value, holds the NZP register, evaluates BEN against the IR nzp field, and keeps a small LIFO of saved condition codes for interrupt entry and return. It sits beside the register file on the shared bus and feeds the control FSM's BEN branch. It adds a direct NZP write port, same-cycle flag forwarding into BEN, and sticky stack-error reporting.

## Interface
- WIDTH, 16, bus width; the sign bit is bit WIDTH-1
- STACK_DEPTH, 4, number of saved-NZP entries (≥1)
- BEN_FWD, 0, 1 = ld_ben in the same cycle as ld_cc/cc_wr uses the new flags; 0 = uses the registered flags
- RESET_NZP, 3'b000, NZP value on reset

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; state clears immediately while low
- bus  in  WIDTH  value sampled for the flags when ld_cc=1
- ld_cc  in  1  load NZP from bus
- ld_ben  in  1  update ben
- ir_nzp  in  3  IR[11:9] branch mask {n,z,p}
- cc_wr  in  1  direct NZP write
- cc_wr_val  in  3  value for cc_wr
- cc_push  in  1  save current NZP onto the stack
- cc_pop  in  1  restore NZP from the top of the stack
- err_clr  in  1  clear stack_err
- nzp  out  3  registered {n,z,p}
- ben  out  1  registered branch enable
- stack_full  out  1  count == STACK_DEPTH
- stack_empty  out  1  count == 0
- stack_depth  out  $clog2(STACK_DEPTH+1)  current entry count
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- Flag decode (combinational): bus==0 → 010; else bus[WIDTH-1]=1 → 100; else 001. The result is always one-hot.
- NZP next-value priority, highest first: valid pop → stack top; cc_wr → cc_wr_val; ld_cc → decoded flags; otherwise hold.
- cc_wr_val is written verbatim. A non-one-hot value is legal and is stored as given.
- BEN: `ben <= |(ir_nzp & src)` when ld_ben=1, else ben holds.
  - src = nzp register when BEN_FWD=0.
  - src = the NZP next-value when BEN_FWD=1.
- Stack is a LIFO of STACK_DEPTH 3-bit entries with a count register:
  - push only, not full: entry[count] <= current nzp (pre-update value); count+1.
  - push only, full: push dropped, contents unchanged, stack_err <= 1.
  - pop only, not empty: nzp <= entry[count-1]; count-1.
  - pop only, empty: nzp follows the remaining priority (cc_wr/ld_cc/hold); count stays 0; stack_err <= 1.
  - push+pop, not empty: swap. nzp <= top; top <= old nzp; count unchanged.
  - push+pop, empty: push proceeds (count becomes 1), pop is ignored, stack_err <= 1.
- stack_err is sticky. err_clr clears it unless a new error occurs in the same cycle, in which case set wins.
- Reset low: nzp=RESET_NZP, ben=0, count=0, stack_err=0, stack_empty=1, stack_full=0, stack_depth=0. Entry contents are don't-care. Reset mid-push or mid-pop aborts the operation with no partial update.

## Timing
- Single clock. Every output is registered or decoded from the count register, so outputs are glitch-free one cycle after the controlling edge.
- Latency:
  - ld_cc/cc_wr/cc_pop → nzp: 1 cycle.
  - ld_ben → ben: 1 cycle.
  - With BEN_FWD=0, ld_ben must follow ld_cc by ≥1 cycle to see the new flags. With BEN_FWD=1, the same cycle suffices.
- Push/pop sustain one operation per cycle, back-to-back, with no bubbles.
- stack_full, stack_empty and stack_depth update in the same cycle as count.
- Reset deassertion is synchronised externally. The block does not re-synchronise it.

## Test plan
- Reset, then ld_cc with bus=0x0000, 0x8001, 0x7FFF on successive cycles → nzp = 010, 100, 001, each one cycle after its load. With WIDTH=8, bus=0x80 → 100.
- BEN_FWD=0: ld_cc bus=0xFFFF with ld_ben and ir_nzp=100 in the same cycle, prior nzp=001 → ben=0. Repeat ld_ben the next cycle → ben=1. BEN_FWD=1, same stimulus → ben=1 after the first cycle.
- Push 001, 010, 100, 001 (STACK_DEPTH=4) → stack_full=1, depth=4. A fifth push → stack_err=1 and depth stays 4. Four pops → nzp = 001, 100, 010, 001; stack_empty=1.
- Pop when empty with ld_cc bus=0x0005 → nzp=001, stack_err=1. err_clr next cycle → stack_err=0. err_clr together with a fresh empty pop → stack_err stays 1.
- nzp=100, stack top=010, depth=2; push+pop in the same cycle → nzp=010, top=100, depth=2. cc_wr=011 together with a valid pop → pop wins.
- Assert reset low asynchronously mid-cycle after three pushes → all outputs reach their reset values before the next clk edge. The first push after release lands at depth 1.
